// File: rtl/generic_2clk_fifo_rd_drain.sv
// Read-domain drain for a dual-clock FIFO: pops when credit allows, absorbs the
// one-cycle register-file latency and re-times words into a 3-deep valid/ready buffer.
module generic_2clk_fifo_rd_drain #(
  parameter int DAT_WIDTH = 20,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_op,
  input  logic [DAT_WIDTH-1:0] fifo_rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DAT_WIDTH-1:0] out_data,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 inflight;
  logic [1:0]           count;
  logic [DAT_WIDTH-1:0] entry [3];
  logic                 depart;
  logic [1:0]           wr_idx;
  logic [2:0]           credit;

  // Credit counts the word still in the RF pipeline, so a capture always has room.
  assign credit    = {1'b0, count} + {2'b00, inflight};
  assign out_valid = (count != 2'd0);
  assign out_data  = entry[0];
  assign depart    = out_valid && out_ready;
  assign wr_idx    = count - {1'b0, depart};
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt  = state;
    fifo_rd_op = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_nxt = STOP;
        end else begin
          fifo_rd_op = !rd_reset && !fifo_empty && (credit < 3'd3);
        end
      end
      STOP: begin
        if (enable) begin
          state_nxt = RUN;
        end else if (!inflight && (count == 2'd0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      count     <= 2'd0;
      pop_count <= '0;
      // NOTE: the buffer entries are reset because out_data is the head entry and must read 0.
      for (int i = 0; i < 3; i++) entry[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let the shift and the tail write below see pre-edge values.
      state    <= state_nxt;
      inflight <= fifo_rd_op;
      count    <= count + {1'b0, inflight} - {1'b0, depart};
      if (fifo_rd_op) pop_count <= pop_count + CNT_WIDTH'(1);
      if (depart) begin
        entry[0] <= entry[1];
        entry[1] <= entry[2];
      end
      // Tail write lands after the shift, so a simultaneous capture keeps order.
      if (inflight) entry[wr_idx] <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_generic_2clk_fifo_rd_drain.sv
// Directed bench for generic_2clk_fifo_rd_drain with a one-cycle-latency RF model
// and a scoreboard of words accepted downstream.
module tb_generic_2clk_fifo_rd_drain;

  localparam int DW = 20;
  localparam int CW = 4;

  logic          rd_clk = 1'b0;
  logic          rd_reset;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_rd_op;
  logic [DW-1:0] fifo_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [CW-1:0] pop_count;

  int            errors = 0;
  int            checks = 0;
  logic          op_neg;
  logic [DW-1:0] src_word;
  logic [DW-1:0] got [$];

  generic_2clk_fifo_rd_drain #(.DAT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rd_clk      (rd_clk),
    .rd_reset    (rd_reset),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_rd_op  (fifo_rd_op),
    .fifo_rd_data(fifo_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .pop_count   (pop_count)
  );

  always #5 rd_clk = ~rd_clk;

  // Pop strobe and downstream transfers sampled mid-cycle.
  initial begin
    op_neg = 1'b0;
    forever begin
      @(negedge rd_clk);
      op_neg = fifo_rd_op;
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  // RF model: word for a pop in cycle N is presented throughout cycle N+1.
  initial begin
    fifo_rd_data = '0;
    src_word     = 20'h00001;
    forever begin
      @(posedge rd_clk);
      #1;
      if (op_neg) begin
        fifo_rd_data = src_word;
        src_word     = src_word + 20'h00001;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rd_reset   = 1'b1;
    enable     = 1'b0;
    fifo_empty = 1'b1;
    out_ready  = 1'b0;

    // Reset state
    tick(); tick(); #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_op",    32'(fifo_rd_op), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_count", 32'(pop_count), 32'd0);
    check("rst_data",  32'(out_data), 32'd0);

    // Streaming: five words, first out_valid two cycles after first pop
    tick();
    rd_reset = 1'b0; enable = 1'b1; fifo_empty = 1'b0; out_ready = 1'b1;
    #1;
    check("idle_no_pop", 32'(fifo_rd_op), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick(); #1;
      check("stream_op", 32'(fifo_rd_op), 32'd1);
      if (i == 2) check("stream_valid_early", 32'(out_valid), 32'd0);
      if (i == 3) begin
        check("stream_first_valid", 32'(out_valid), 32'd1);
        check("stream_first_data",  32'(out_data), 32'h00001);
      end
    end
    tick(); fifo_empty = 1'b1; #1;
    check("stream_empty_no_pop", 32'(fifo_rd_op), 32'd0);
    tick(); tick(); #1;
    check("stream_drained",   32'(out_valid), 32'd0);
    check("stream_pop_count", 32'(pop_count), 32'd5);
    check("stream_n_words",   32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("stream_word", 32'(got[i]), 32'(i + 1));

    // Backpressure: three pops fill the buffer, then release
    got.delete();
    tick(); fifo_empty = 1'b0; out_ready = 1'b0; #1;
    check("bp_pop0", 32'(fifo_rd_op), 32'd1);
    tick(); #1;
    check("bp_pop1", 32'(fifo_rd_op), 32'd1);
    tick(); #1;
    check("bp_pop2",  32'(fifo_rd_op), 32'd1);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_head",  32'(out_data), 32'h00006);
    for (int i = 3; i <= 5; i++) begin
      tick(); #1;
      check("bp_no_pop",     32'(fifo_rd_op), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data",  32'(out_data), 32'h00006);
    end
    tick(); out_ready = 1'b1; #1;
    check("bp_full_no_pop", 32'(fifo_rd_op), 32'd0);
    tick(); #1;
    check("bp_resume_pop", 32'(fifo_rd_op), 32'd1);
    tick();
    tick(); fifo_empty = 1'b1; #1;
    check("bp_empty_no_pop", 32'(fifo_rd_op), 32'd0);
    tick(); tick(); #1;
    check("bp_drained",   32'(out_valid), 32'd0);
    check("bp_pop_count", 32'(pop_count), 32'd10);
    check("bp_n_words",   32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("bp_word", 32'(got[i]), 32'(i + 6));

    // Orderly stop right after a pop
    got.delete();
    tick(); fifo_empty = 1'b0; #1;
    check("stop_last_pop", 32'(fifo_rd_op), 32'd1);
    tick(); enable = 1'b0; #1;
    check("stop_no_pop", 32'(fifo_rd_op), 32'd0);
    check("stop_busy1",  32'(busy), 32'd1);
    tick(); #1;
    check("stop_valid", 32'(out_valid), 32'd1);
    check("stop_data",  32'(out_data), 32'h0000B);
    check("stop_no_pop2", 32'(fifo_rd_op), 32'd0);
    check("stop_busy2", 32'(busy), 32'd1);
    tick(); #1;
    check("stop_drained", 32'(out_valid), 32'd0);
    check("stop_busy3",   32'(busy), 32'd1);
    tick(); #1;
    check("stop_idle",      32'(busy), 32'd0);
    check("stop_idle_op",   32'(fifo_rd_op), 32'd0);
    check("stop_n_words",   32'(got.size()), 32'd1);
    check("stop_pop_count", 32'(pop_count), 32'd11);

    // fifo_empty toggling every cycle
    got.delete();
    tick(); enable = 1'b1; fifo_empty = 1'b1; #1;
    check("tog_idle_op", 32'(fifo_rd_op), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick(); fifo_empty = (i % 2 == 0); #1;
      check("tog_op", 32'(fifo_rd_op), 32'(i % 2));
    end
    tick(); tick(); tick(); #1;
    check("tog_drained",   32'(out_valid), 32'd0);
    check("tog_pop_count", 32'(pop_count), 32'd15);
    check("tog_n_words",   32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("tog_word", 32'(got[i]), 32'(i + 12));

    // Reset with two buffered words and one read in flight
    got.delete();
    tick(); out_ready = 1'b0; fifo_empty = 1'b0;
    tick(); tick();
    tick(); rd_reset = 1'b1; #1;
    check("rr_pre_valid", 32'(out_valid), 32'd1);
    check("rr_pre_head",  32'(out_data), 32'h00010);
    check("rr_pre_wrap",  32'(pop_count), 32'd2);
    check("rr_pre_op",    32'(fifo_rd_op), 32'd0);
    tick(); rd_reset = 1'b0; fifo_empty = 1'b1; out_ready = 1'b1; #1;
    check("rr_valid", 32'(out_valid), 32'd0);
    check("rr_count", 32'(pop_count), 32'd0);
    check("rr_busy",  32'(busy), 32'd0);
    check("rr_data",  32'(out_data), 32'd0);
    tick(); tick(); #1;
    check("rr_late_valid", 32'(out_valid), 32'd0);
    check("rr_n_words",    32'(got.size()), 32'd0);

    // Counter wrap: 17 pops on a 4-bit counter
    got.delete();
    tick(); fifo_empty = 1'b0;
    repeat (16) tick();
    tick(); fifo_empty = 1'b1;
    tick(); tick(); tick(); #1;
    check("wrap_pop_count", 32'(pop_count), 32'd1);
    check("wrap_n_words",   32'(got.size()), 32'd17);
    for (int i = 0; i < 17; i++) check("wrap_word", 32'(got[i]), 32'(i + 19));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
